// File: rtl/free_bufid_manage_pkg.sv
// Shared types and defaults for the free-buffer-ID manager, its FIFO, and the
// dispatch/transmit blocks that exchange buffer IDs with it.
package free_bufid_manage_pkg;

  localparam int unsigned BUF_NUM_DEF = 256;
  localparam int unsigned BUFID_W_DEF = 9;

  typedef logic [BUFID_W_DEF-1:0] bufid_t;

  typedef enum logic [1:0] {
    INIT_S = 2'd0,
    RUN_S  = 2'd1
  } fbm_state_e;

endpackage

// File: rtl/free_bufid_manage_bufid_fifo.sv
// Show-ahead FIFO holding free buffer IDs; the head is readable before pop.
// Full/empty come from the occupancy count, so pointers simply wrap at Depth.
module free_bufid_manage_bufid_fifo #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 9,
  parameter int unsigned CntW  = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: contents are only ever read after being written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/free_bufid_manage.sv
// Free-buffer-ID manager: fills the pool with IDs 0..BUF_NUM-1 after reset, offers
// one ID at a time to dispatch and takes released IDs back from the transmit side.
module free_bufid_manage
  import free_bufid_manage_pkg::*;
#(
  parameter int unsigned BUF_NUM = BUF_NUM_DEF,
  parameter int unsigned BUFID_W = BUFID_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [BUFID_W-1:0] ov_bufid,
  output logic               o_bufid_wr,
  input  logic               i_bufid_ack,
  input  logic [BUFID_W-1:0] iv_release_bufid,
  input  logic               i_release_wr,
  output logic [BUFID_W-1:0] ov_free_bufid_num,
  output logic               o_init_done,
  output logic               o_release_error_pulse,
  output logic [1:0]         ov_fbm_state
);

  fbm_state_e         state_q, state_d;
  logic [BUFID_W-1:0] init_cnt_q, init_cnt_d;
  logic               init_done_q, init_done_d;
  logic [BUFID_W-1:0] bufid_q, bufid_d;
  logic               bufid_wr_q, bufid_wr_d;
  logic [BUFID_W-1:0] free_num_q, free_num_d;
  logic               err_q, err_d;

  logic               fifo_push;
  logic [BUFID_W-1:0] fifo_push_data;
  logic               fifo_pop;
  logic [BUFID_W-1:0] fifo_head;
  logic               fifo_empty;
  logic [BUFID_W-1:0] fifo_count;
  logic               ack_ok;
  logic               rel_ok;

  free_bufid_manage_bufid_fifo #(
    .Depth (BUF_NUM),
    .Width (BUFID_W),
    .CntW  (BUFID_W)
  ) u_bufid_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign ack_ok = i_bufid_ack && bufid_wr_q;
  // The FIFO-count guard is redundant with the pool-full check but keeps the FIFO safe.
  assign rel_ok = i_release_wr && (state_q == RUN_S)
                  && (iv_release_bufid < BUFID_W'(BUF_NUM))
                  && (free_num_q != BUFID_W'(BUF_NUM))
                  && (fifo_count != BUFID_W'(BUF_NUM));

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    init_done_d    = init_done_q;
    bufid_d        = bufid_q;
    bufid_wr_d     = bufid_wr_q;
    free_num_d     = free_num_q;
    err_d          = i_release_wr && !rel_ok;
    fifo_push      = 1'b0;
    fifo_push_data = init_cnt_q;
    fifo_pop       = 1'b0;

    unique case (state_q)
      INIT_S: begin
        fifo_push  = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        free_num_d = free_num_q + 1'b1;
        if (init_cnt_q == BUFID_W'(BUF_NUM - 1)) begin
          state_d     = RUN_S;
          init_done_d = 1'b1;
        end
      end
      RUN_S: begin
        if (rel_ok) begin
          fifo_push      = 1'b1;
          fifo_push_data = iv_release_bufid;
        end
        // A released ID never bypasses the FIFO, so only the current head is offered.
        if (!fifo_empty && (!bufid_wr_q || ack_ok)) begin
          fifo_pop   = 1'b1;
          bufid_d    = fifo_head;
          bufid_wr_d = 1'b1;
        end else if (ack_ok) begin
          bufid_wr_d = 1'b0;
        end
        free_num_d = free_num_q + BUFID_W'(rel_ok) - BUFID_W'(ack_ok);
      end
      default: state_d = INIT_S;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= INIT_S;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      bufid_q     <= '0;
      bufid_wr_q  <= 1'b0;
      free_num_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      bufid_q     <= bufid_d;
      bufid_wr_q  <= bufid_wr_d;
      free_num_q  <= free_num_d;
      err_q       <= err_d;
    end
  end

  assign ov_bufid              = bufid_q;
  assign o_bufid_wr            = bufid_wr_q;
  assign ov_free_bufid_num     = free_num_q;
  assign o_init_done           = init_done_q;
  assign o_release_error_pulse = err_q;
  assign ov_fbm_state          = state_q;

endmodule

// File: tb/tb_free_bufid_manage.sv
// Directed bench for free_bufid_manage: init, mid-init reset, drain, release,
// simultaneous ack/release and the three release-error cases.
module tb_free_bufid_manage;
  import free_bufid_manage_pkg::*;

  logic       clk;
  logic       rst;
  bufid_t     bufid;
  logic       bufid_wr;
  logic       bufid_ack;
  bufid_t     rel_id;
  logic       rel_wr;
  bufid_t     free_num;
  logic       init_done;
  logic       err_pulse;
  logic [1:0] fbm_state;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  free_bufid_manage dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .ov_bufid              (bufid),
    .o_bufid_wr            (bufid_wr),
    .i_bufid_ack           (bufid_ack),
    .iv_release_bufid      (rel_id),
    .i_release_wr          (rel_wr),
    .ov_free_bufid_num     (free_num),
    .o_init_done           (init_done),
    .o_release_error_pulse (err_pulse),
    .ov_fbm_state          (fbm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " bufid"}, 32'(bufid), 0);
    chk({tag, " bufid_wr"}, 32'(bufid_wr), 0);
    chk({tag, " count"}, 32'(free_num), 0);
    chk({tag, " init_done"}, 32'(init_done), 0);
    chk({tag, " err"}, 32'(err_pulse), 0);
    chk({tag, " state"}, 32'(fbm_state), 0);
  endtask

  int unsigned exp_ids[10];

  initial begin
    rst       = 1'b1;
    bufid_ack = 1'b0;
    rel_id    = '0;
    rel_wr    = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");

    // First init, interrupted by reset after edge 99.
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
    end
    chk("init1 count@99", 32'(free_num), 100);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    tick();
    rst = 1'b0;

    // Second init, with a release attempted during INIT_S at edge 50.
    for (int k = 0; k < 256; k++) begin
      if (k == 50) begin
        rel_wr = 1'b1;
        rel_id = 9'd3;
      end
      tick();
      rel_wr = 1'b0;
      if (k == 50) begin
        chk("init err pulse", 32'(err_pulse), 1);
        chk("init err count", 32'(free_num), 51);
      end
      if (k == 51) begin
        chk("init err clears", 32'(err_pulse), 0);
        chk("init count@51", 32'(free_num), 52);
      end
      if (k == 254) begin
        chk("init_done@254", 32'(init_done), 0);
        chk("state@254", 32'(fbm_state), 0);
      end
    end
    chk("init_done@255", 32'(init_done), 1);
    chk("state@255", 32'(fbm_state), 1);
    chk("bufid_wr@255", 32'(bufid_wr), 0);
    chk("count@255", 32'(free_num), 256);
    tick();
    chk("bufid@256", 32'(bufid), 0);
    chk("bufid_wr@256", 32'(bufid_wr), 1);
    chk("count@256", 32'(free_num), 256);

    // Release while full.
    rel_wr = 1'b1;
    rel_id = 9'd7;
    tick();
    rel_wr = 1'b0;
    chk("full err pulse", 32'(err_pulse), 1);
    chk("full err count", 32'(free_num), 256);
    tick();
    chk("full err clears", 32'(err_pulse), 0);
    chk("full count kept", 32'(free_num), 256);

    // Drain the whole pool back-to-back.
    bufid_ack = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("drain id %0d", i), 32'(bufid), 32'(i));
      chk($sformatf("drain wr %0d", i), 32'(bufid_wr), 1);
      chk($sformatf("drain count %0d", i), 32'(free_num), 32'(256 - i));
      tick();
    end
    chk("drained wr", 32'(bufid_wr), 0);
    chk("drained count", 32'(free_num), 0);
    tick();
    bufid_ack = 1'b0;
    chk("extra ack wr", 32'(bufid_wr), 0);
    chk("extra ack count", 32'(free_num), 0);

    // Release 37 into an empty pool: push edge, then offer edge.
    rel_wr = 1'b1;
    rel_id = 9'd37;
    tick();
    rel_wr = 1'b0;
    chk("rel37 push wr", 32'(bufid_wr), 0);
    chk("rel37 push count", 32'(free_num), 1);
    tick();
    chk("rel37 bufid", 32'(bufid), 37);
    chk("rel37 wr", 32'(bufid_wr), 1);
    chk("rel37 count", 32'(free_num), 1);

    // Out-of-range release.
    rel_wr = 1'b1;
    rel_id = 9'd300;
    tick();
    rel_wr = 1'b0;
    chk("id300 err pulse", 32'(err_pulse), 1);
    chk("id300 count", 32'(free_num), 1);
    tick();
    chk("id300 err clears", 32'(err_pulse), 0);
    chk("id300 count kept", 32'(free_num), 1);

    // Fill to count 10 with IDs 100..108 behind the offered 37.
    for (int i = 0; i < 9; i++) begin
      rel_wr = 1'b1;
      rel_id = 9'(100 + i);
      tick();
    end
    rel_wr = 1'b0;
    chk("fill count", 32'(free_num), 10);
    chk("fill bufid", 32'(bufid), 37);

    // Simultaneous ack and release of 5.
    bufid_ack = 1'b1;
    rel_wr    = 1'b1;
    rel_id    = 9'd5;
    tick();
    rel_wr = 1'b0;
    chk("simul count", 32'(free_num), 10);
    chk("simul bufid", 32'(bufid), 100);
    chk("simul wr", 32'(bufid_wr), 1);
    chk("simul err", 32'(err_pulse), 0);

    for (int i = 0; i < 8; i++) exp_ids[i] = 32'(101 + i);
    exp_ids[8] = 5;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("tail id %0d", i), 32'(bufid), exp_ids[i]);
    end
    chk("tail count", 32'(free_num), 1);
    tick();
    bufid_ack = 1'b0;
    chk("final wr", 32'(bufid_wr), 0);
    chk("final count", 32'(free_num), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/free_bufid_manage.md
# free_bufid_manage

Free-buffer-ID manager for the host receive path: owns the pool of packet-buffer IDs, hands one ID at a time to the packet map/dispatch stage, and takes IDs back from the transmit side once packets are read out. It also reports the live free-ID count, which the dispatch stage compares against RC/BE discard thresholds. After reset it self-initialises the pool (IDs 0..BUF_NUM-1) before issuing any ID.

## Interface
- BUF_NUM, 256: number of packet buffers; IDs 0..BUF_NUM-1; at most 2^BUFID_W-1.
- BUFID_W, 9: buffer-ID width.

- i_clk  in  1  single clock; every register is clocked on its rising edge.
- i_rst  in  1  asynchronous active-high reset.
- ov_bufid  out  BUFID_W  ID offered to dispatch.
- o_bufid_wr  out  1  ov_bufid valid; held until acked.
- i_bufid_ack  in  1  one-cycle pulse: dispatch took ov_bufid.
- iv_release_bufid  in  BUFID_W  ID returned to the pool.
- i_release_wr  in  1  one-cycle strobe for iv_release_bufid.
- ov_free_bufid_num  out  BUFID_W  free IDs = FIFO entries + o_bufid_wr.
- o_init_done  out  1  high once pool initialisation is complete.
- o_release_error_pulse  out  1  one-cycle pulse: release dropped.
- ov_fbm_state  out  2  current FSM state, for debug.

## Operation
- FSM states: INIT_S=0, RUN_S=1.
- INIT_S: one ID per cycle, 0 upward, is written into the FIFO. The write of BUF_NUM-1 moves the FSM to RUN_S and sets o_init_done.
- RUN_S, offer: when o_bufid_wr=0 and the FIFO is non-empty, pop the head into ov_bufid and set o_bufid_wr.
- RUN_S, ack: i_bufid_ack with o_bufid_wr=1 consumes the offered ID.
  - FIFO non-empty: the next ID loads on the same edge and o_bufid_wr stays 1, so back-to-back acks give one ID per cycle.
  - FIFO empty: o_bufid_wr clears.
- Ack while o_bufid_wr=0: ignored. Count unchanged.
- Release in RUN_S: the ID is pushed into the FIFO, unless any of these holds, in which case it is dropped and o_release_error_pulse fires:
  - iv_release_bufid >= BUF_NUM;
  - ov_free_bufid_num == BUF_NUM (pool already full);
  - FSM is in INIT_S.
- Simultaneous ack and release: both are honoured. The released ID goes to the FIFO tail; there is no bypass into ov_bufid.
  - If the FIFO was empty, the released ID is offered on the following cycle.
- Count arithmetic: count_next = count − (ack accepted) + (release accepted). The count is BUFID_W wide and never exceeds BUF_NUM or drops below 0.
- IDs are issued in strict FIFO order.
- No duplicate-release detection beyond the full check; the transmit side guarantees each ID is released once.

## Timing
- Reset values: ov_bufid=0, o_bufid_wr=0, ov_free_bufid_num=0, o_init_done=0, o_release_error_pulse=0, ov_fbm_state=INIT_S. FIFO pointers are 0.
- Edges are counted from the first rising edge after i_rst deasserts, numbered edge 0.
  - Edge k (0 ≤ k < BUF_NUM) writes ID k; the count becomes k+1.
  - Edge BUF_NUM−1: o_init_done=1 and the FSM enters RUN_S.
  - Edge BUF_NUM: ov_bufid=0, o_bufid_wr=1, count=BUF_NUM.
- Ack→next offer latency: 0 cycles when the FIFO is non-empty.
- Release into an empty pool → offer latency: 2 edges (push, then load).
- Every output is registered.
- i_rst asserted mid-operation: all state clears asynchronously, all outstanding IDs are forgotten, and re-initialisation starts on release of i_rst.
- FIFO pointers are log2(BUF_NUM) bits wide and wrap modulo BUF_NUM. Full/empty are derived from the count, not from pointer equality.

## Structure
- Shared package:
  - BUF_NUM and BUFID_W defaults;
  - FSM state encoding (INIT_S, RUN_S);
  - the bufid width typedef, so dispatch and the transmit side use the same type.
- Sub-module bufid_fifo: synchronous show-ahead FIFO, depth BUF_NUM, width BUFID_W.
  - Push and pop in the same cycle are allowed.
  - Provides empty and count outputs.
  - The top level holds the FSM, init counter, offer register and release checks.

## Test plan
- Reset release, no traffic: o_init_done rises after edge 255; at edge 256 ov_bufid=0, o_bufid_wr=1, ov_free_bufid_num=256.
- Ack 256 times back-to-back: IDs 0..255 in order, one per cycle; then o_bufid_wr=0 and the count is 0; an extra ack is ignored and the count stays 0.
- Pool empty, release ID 37: two edges later ov_bufid=37, o_bufid_wr=1, count=1.
- Count=10 with o_bufid_wr=1, ack and release ID 5 in the same cycle: count stays 10, the next offered ID is the old FIFO head, and ID 5 is appended at the tail.
- Error releases give o_release_error_pulse=1 for exactly one cycle with the count unchanged, for each of:
  - release ID 300;
  - release while count=256;
  - release during INIT_S.
- Assert i_rst at edge 100 of init: all outputs return to reset values; after deassert, init restarts from ID 0 and completes 256 edges later.
